// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: FSM states, UART address
// match, access-size codes and the load-extension helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_FETCH = 2'd3
    } state_e;

    // io_addr[17:16] value that selects the UART
    localparam logic [1:0] IO_SEL = 2'b11;

    // io_op[1:0] size codes
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Number of bytes moved for a size code
    function automatic logic [2:0] op_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Sign/zero extension of an assembled load; op[2] selects unsigned
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] op);
        case (op[1:0])
            SZ_B:    return op[2] ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            SZ_H:    return op[2] ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating LSB loads/stores and
// instruction fetches onto a single 8-bit RAM port with one-cycle read
// latency. While rdy_in is low the RAM keeps running on the held address,
// so the byte that was due on mem_din is parked in a one-entry skid and
// replayed on the first enabled edge.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        is_io,
    input  logic        is_store,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_data,
    input  logic [2:0]  io_op,
    output logic        mem_res_avail,
    output logic [31:0] mem_res,
    output logic        mem_stuck,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst
);

    state_e      state_q;
    logic [2:0]  cnt_q;          // edges since accept; also byte offset
    logic [2:0]  size_q;
    logic [2:0]  op_q;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] asm_q;
    logic        clr_q;          // flush seen during a store
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;
    logic        mem_res_avail_q;
    logic [31:0] mem_res_q;
    logic        if_done_q;
    logic [31:0] if_inst_q;
    logic        hold_vld_q;
    logic [7:0]  hold_byte_q;

    logic [7:0]  din_eff;
    logic [2:0]  nxt;
    logic [1:0]  cap_idx;
    logic [31:0] asm_fin;
    logic        can_acc;
    logic        io_go;

    // Byte assembly and accept qualification
    always_comb begin
        din_eff = hold_vld_q ? hold_byte_q : mem_din;
        nxt     = cnt_q + 3'd1;
        // byte k-1 arrives on the edge where cnt_q == k
        cap_idx = cnt_q[1:0] - 2'd1;
        asm_fin = asm_q;
        asm_fin[{cap_idx, 3'b000} +: 8] = din_eff;
        can_acc = !rob_clear && !mem_res_avail_q && !if_done_q;
        io_go   = is_io && !(is_store && (io_addr[17:16] == IO_SEL) && io_buffer_full);
    end

    // Main controller FSM with registered RAM-side and result outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            size_q          <= '0;
            op_q            <= '0;
            base_q          <= '0;
            wdata_q         <= '0;
            asm_q           <= '0;
            clr_q           <= 1'b0;
            mem_a_q         <= '0;
            mem_dout_q      <= '0;
            mem_wr_q        <= 1'b0;
            mem_res_avail_q <= 1'b0;
            mem_res_q       <= '0;
            if_done_q       <= 1'b0;
            if_inst_q       <= '0;
            hold_vld_q      <= 1'b0;
            hold_byte_q     <= '0;
        end else if (!rdy_in) begin
            if (!hold_vld_q) begin
                hold_byte_q <= mem_din;
                hold_vld_q  <= 1'b1;
            end
        end else begin
            hold_vld_q      <= 1'b0;
            mem_res_avail_q <= 1'b0;
            if_done_q       <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (can_acc && io_go) begin
                        base_q  <= io_addr;
                        mem_a_q <= io_addr;
                        cnt_q   <= '0;
                        size_q  <= op_bytes(io_op[1:0]);
                        op_q    <= io_op;
                        clr_q   <= 1'b0;
                        if (is_store) begin
                            state_q    <= ST_STORE;
                            wdata_q    <= io_data;
                            mem_dout_q <= io_data[7:0];
                            mem_wr_q   <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end else if (can_acc && if_req) begin
                        base_q  <= if_addr;
                        mem_a_q <= if_addr;
                        cnt_q   <= '0;
                        size_q  <= 3'd4;
                        state_q <= ST_FETCH;
                    end
                end
                ST_LOAD, ST_FETCH: begin
                    if (rob_clear) begin
                        state_q  <= ST_IDLE;
                        mem_a_q  <= '0;
                        mem_wr_q <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= nxt;
                        if (nxt < size_q)
                            mem_a_q <= base_q + 32'(nxt);
                        if (cnt_q != 3'd0)
                            asm_q <= asm_fin;
                        if (cnt_q == size_q) begin
                            state_q <= ST_IDLE;
                            mem_a_q <= '0;
                            cnt_q   <= '0;
                            if (state_q == ST_LOAD) begin
                                mem_res_q       <= load_ext(asm_fin, op_q);
                                mem_res_avail_q <= 1'b1;
                            end else begin
                                if_inst_q <= asm_fin;
                                if_done_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_STORE: begin
                    // a flush never cuts a store short, it only hides the pulse
                    if (rob_clear)
                        clr_q <= 1'b1;
                    if (nxt < size_q) begin
                        cnt_q      <= nxt;
                        mem_a_q    <= base_q + 32'(nxt);
                        mem_dout_q <= wdata_q[{nxt[1:0], 3'b000} +: 8];
                    end else begin
                        state_q         <= ST_IDLE;
                        cnt_q           <= '0;
                        mem_a_q         <= '0;
                        mem_wr_q        <= 1'b0;
                        mem_res_q       <= '0;
                        mem_res_avail_q <= !(clr_q || rob_clear);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_a         = mem_a_q;
    assign mem_dout      = mem_dout_q;
    assign mem_wr        = mem_wr_q & rdy_in;
    assign mem_res_avail = mem_res_avail_q;
    assign mem_res       = mem_res_q;
    assign if_done       = if_done_q;
    assign if_inst       = if_inst_q;
    assign mem_stuck     = io_buffer_full;

endmodule
